// File: rtl/legv8_pkg.sv
// Shared types and encodings for the multi-cycle LEGv8 control path.
package legv8_pkg;

  localparam int unsigned OpW = 11;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StAluWb   = 4'd3,
    StMemAddr = 4'd4,
    StMemRd   = 4'd5,
    StMemWb   = 4'd6,
    StMemWr   = 4'd7,
    StBranch  = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    OpClsR,
    OpClsLdur,
    OpClsStur,
    OpClsCbz,
    OpClsInvalid
  } op_class_e;

  // Opcode patterns as value/care pairs; a 0 care bit is a don't-care.
  localparam logic [OpW-1:0] OpcRArithVal  = 11'b10001011000;  // ADD, SUB
  localparam logic [OpW-1:0] OpcRArithCare = 11'b10111111111;
  localparam logic [OpW-1:0] OpcRLogicVal  = 11'b10001010000;  // AND, ORR
  localparam logic [OpW-1:0] OpcRLogicCare = 11'b11011111111;
  localparam logic [OpW-1:0] OpcSturVal    = 11'b11111000000;
  localparam logic [OpW-1:0] OpcLdurVal    = 11'b11111000010;
  localparam logic [OpW-1:0] OpcFullCare   = 11'b11111111111;
  localparam logic [OpW-1:0] OpcCbzVal     = 11'b10110100000;
  localparam logic [OpW-1:0] OpcCbzCare    = 11'b11111111000;

  localparam logic [1:0] AluSrcBRegB   = 2'b00;
  localparam logic [1:0] AluSrcBFour   = 2'b01;
  localparam logic [1:0] AluSrcBImm    = 2'b10;
  localparam logic [1:0] AluSrcBBrOff  = 2'b11;

  localparam logic [1:0] AluOpAdd      = 2'b00;
  localparam logic [1:0] AluOpPassB    = 2'b01;
  localparam logic [1:0] AluOpFunct    = 2'b10;

  function automatic logic op_match(input logic [OpW-1:0] op, input logic [OpW-1:0] val,
                                    input logic [OpW-1:0] care);
    return ((op ^ val) & care) == '0;
  endfunction

endpackage

// File: rtl/legv8_opclass.sv
// Combinational opcode classifier for the LEGv8 control FSM.
module legv8_opclass
  import legv8_pkg::*;
(
  input  logic [OpW-1:0] op_i,
  output op_class_e      class_o
);

  always_comb begin
    class_o = OpClsInvalid;
    if (op_match(op_i, OpcRArithVal, OpcRArithCare) ||
        op_match(op_i, OpcRLogicVal, OpcRLogicCare)) begin
      class_o = OpClsR;
    end else if (op_match(op_i, OpcSturVal, OpcFullCare)) begin
      class_o = OpClsStur;
    end else if (op_match(op_i, OpcLdurVal, OpcFullCare)) begin
      class_o = OpClsLdur;
    end else if (op_match(op_i, OpcCbzVal, OpcCbzCare)) begin
      class_o = OpClsCbz;
    end
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: sequences PC, IR, ALU, register file and data memory,
// and counts retired instructions.
module legv8_multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int unsigned OP_W  = 11,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  Op,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IRWrite,
  output logic             Reg2Loc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [CNT_W-1:0] InstrCount,
  output logic [3:0]       State
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_class_e        op_class;
  logic             retire;

  legv8_opclass u_opclass (
    .op_i    (Op),
    .class_o (op_class)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:   state_d = StDecode;
      StDecode: begin
        unique case (op_class)
          OpClsR:               state_d = StExecR;
          OpClsLdur, OpClsStur: state_d = StMemAddr;
          OpClsCbz:             state_d = StBranch;
          default:              state_d = StFetch;
        endcase
      end
      StExecR:   state_d = StAluWb;
      StAluWb:   state_d = StFetch;
      StMemAddr: state_d = (op_class == OpClsStur) ? StMemWr : StMemRd;
      StMemRd:   state_d = MemReady ? StMemWb : StMemRd;
      StMemWb:   state_d = StFetch;
      StMemWr:   state_d = MemReady ? StFetch : StMemWr;
      StBranch:  state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    retire = (state_q == StAluWb) || (state_q == StMemWb) || (state_q == StBranch) ||
             ((state_q == StMemWr) && MemReady) ||
             ((state_q == StDecode) && (op_class == OpClsInvalid));
    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IRWrite  = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = AluSrcBRegB;
    ALUOp    = AluOpAdd;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    unique case (state_q)
      StFetch: begin
        IRWrite = 1'b1;
        ALUSrcB = AluSrcBFour;
        PCWrite = 1'b1;
      end
      StDecode: begin
        ALUSrcB = AluSrcBBrOff;
        Reg2Loc = (op_class == OpClsStur) || (op_class == OpClsCbz);
      end
      StExecR: begin
        ALUSrcA = 1'b1;
        ALUOp   = AluOpFunct;
      end
      StAluWb: RegWrite = 1'b1;
      StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = AluSrcBImm;
        Reg2Loc = (op_class == OpClsStur);
      end
      StMemRd: MemRead = 1'b1;
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        Reg2Loc  = 1'b1;
      end
      StBranch: begin
        Reg2Loc = 1'b1;
        ALUSrcA = 1'b1;
        ALUOp   = AluOpPassB;
        PCSrc   = 1'b1;
        PCWrite = Zero;
      end
      default: ;
    endcase
  end

  assign InstrCount = cnt_q;
  assign State      = state_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed table-driven bench for legv8_multicycle_ctrl plus async-reset and wrap checks.
module tb_legv8_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] Op;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite, PCSrc, IRWrite, Reg2Loc, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp;
  logic        MemRead, MemWrite, MemtoReg, RegWrite;
  logic [31:0] InstrCount;
  logic [3:0]  State;

  // Narrow-counter instance sharing the same stimulus to observe wraparound.
  logic        w_pcw, w_pcs, w_irw, w_r2l, w_asa, w_mr, w_mw, w_m2r, w_rw;
  logic [1:0]  w_asb, w_aop;
  logic [2:0]  w_cnt;
  logic [3:0]  w_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  legv8_multicycle_ctrl #(.OP_W(11), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .Reg2Loc(Reg2Loc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .InstrCount(InstrCount), .State(State)
  );

  legv8_multicycle_ctrl #(.OP_W(11), .CNT_W(3)) dut_w (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(w_pcw), .PCSrc(w_pcs), .IRWrite(w_irw), .Reg2Loc(w_r2l),
    .ALUSrcA(w_asa), .ALUSrcB(w_asb), .ALUOp(w_aop), .MemRead(w_mr),
    .MemWrite(w_mw), .MemtoReg(w_m2r), .RegWrite(w_rw),
    .InstrCount(w_cnt), .State(w_state)
  );

  typedef struct packed {
    logic [10:0] op;
    logic        zero;
    logic        mrdy;
    logic [3:0]  st;
    logic [12:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  // {PCWrite,PCSrc,IRWrite,Reg2Loc,ALUSrcA,ALUSrcB,ALUOp,MemRead,MemWrite,MemtoReg,RegWrite}
  function automatic logic [12:0] c(input logic pcw, input logic pcs, input logic irw,
                                    input logic r2l, input logic asa, input logic [1:0] asb,
                                    input logic [1:0] aop, input logic mr, input logic mw,
                                    input logic m2r, input logic rw);
    return {pcw, pcs, irw, r2l, asa, asb, aop, mr, mw, m2r, rw};
  endfunction

  function automatic logic [12:0] ctl_now();
    return {PCWrite, PCSrc, IRWrite, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp,
            MemRead, MemWrite, MemtoReg, RegWrite};
  endfunction

  task automatic add(input logic [10:0] op, input logic zero, input logic mrdy,
                     input logic [3:0] st, input logic [12:0] ctl, input logic [31:0] cnt);
    vec_t v;
    v.op = op; v.zero = zero; v.mrdy = mrdy; v.st = st; v.ctl = ctl; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpCbz  = 11'b10110100101;
  localparam logic [10:0] OpNop  = 11'b00000000000;
  localparam logic [10:0] OpBad  = 11'b11111000001;

  logic [12:0] k_fetch, k_dec0, k_dec1, k_execr, k_aluwb, k_maddr_l, k_maddr_s;
  logic [12:0] k_memrd, k_memwb, k_memwr, k_br_z, k_br_n;

  initial begin
    k_fetch   = c(1, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    k_dec0    = c(0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);
    k_dec1    = c(0, 0, 0, 1, 0, 2'b11, 2'b00, 0, 0, 0, 0);
    k_execr   = c(0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0, 0, 0);
    k_aluwb   = c(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1);
    k_maddr_l = c(0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0);
    k_maddr_s = c(0, 0, 0, 1, 1, 2'b10, 2'b00, 0, 0, 0, 0);
    k_memrd   = c(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    k_memwb   = c(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1);
    k_memwr   = c(0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 0, 0);
    k_br_z    = c(1, 1, 0, 1, 1, 2'b00, 2'b01, 0, 0, 0, 0);
    k_br_n    = c(0, 1, 0, 1, 1, 2'b00, 2'b01, 0, 0, 0, 0);

    // ADD: 4 cycles
    add(OpAdd, 0, 1, 4'd0, k_fetch, 0);
    add(OpAdd, 0, 1, 4'd1, k_dec0, 0);
    add(OpAdd, 0, 0, 4'd2, k_execr, 0);
    add(OpAdd, 1, 1, 4'd3, k_aluwb, 0);
    // LDUR, MemReady low for 3 cycles: 8 cycles
    add(OpLdur, 0, 1, 4'd0, k_fetch, 1);
    add(OpLdur, 1, 1, 4'd1, k_dec0, 1);
    add(OpLdur, 0, 1, 4'd4, k_maddr_l, 1);
    add(OpLdur, 0, 0, 4'd5, k_memrd, 1);
    add(OpLdur, 0, 0, 4'd5, k_memrd, 1);
    add(OpLdur, 0, 0, 4'd5, k_memrd, 1);
    add(OpLdur, 0, 1, 4'd5, k_memrd, 1);
    add(OpLdur, 0, 0, 4'd6, k_memwb, 1);
    // STUR, ready at once: 4 cycles
    add(OpStur, 0, 1, 4'd0, k_fetch, 2);
    add(OpStur, 0, 1, 4'd1, k_dec1, 2);
    add(OpStur, 0, 1, 4'd4, k_maddr_s, 2);
    add(OpStur, 0, 1, 4'd7, k_memwr, 2);
    // STUR with one wait cycle
    add(OpStur, 0, 0, 4'd0, k_fetch, 3);
    add(OpStur, 0, 0, 4'd1, k_dec1, 3);
    add(OpStur, 0, 0, 4'd4, k_maddr_s, 3);
    add(OpStur, 0, 0, 4'd7, k_memwr, 3);
    add(OpStur, 0, 1, 4'd7, k_memwr, 3);
    // CBZ taken / not taken: 3 cycles each
    add(OpCbz, 1, 0, 4'd0, k_fetch, 4);
    add(OpCbz, 1, 0, 4'd1, k_dec1, 4);
    add(OpCbz, 1, 0, 4'd8, k_br_z, 4);
    add(OpCbz, 0, 1, 4'd0, k_fetch, 5);
    add(OpCbz, 0, 1, 4'd1, k_dec1, 5);
    add(OpCbz, 0, 1, 4'd8, k_br_n, 5);
    // Invalid opcode: 2 cycles, still retires
    add(OpNop, 0, 1, 4'd0, k_fetch, 6);
    add(OpNop, 0, 1, 4'd1, k_dec0, 6);
    // ORR (second R pattern)
    add(OpOrr, 0, 1, 4'd0, k_fetch, 7);
    add(OpOrr, 0, 1, 4'd1, k_dec0, 7);
    add(OpOrr, 0, 1, 4'd2, k_execr, 7);
    add(OpOrr, 0, 1, 4'd3, k_aluwb, 7);
    // Near-LDUR opcode is invalid
    add(OpBad, 0, 1, 4'd0, k_fetch, 8);
    add(OpBad, 0, 1, 4'd1, k_dec0, 8);
    add(OpLdur, 0, 1, 4'd0, k_fetch, 9);

    reset    = 1'b1;
    Op       = OpNop;
    Zero     = 1'b0;
    MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", 32'(State), 32'd0);
    chk("reset count", InstrCount, 32'd0);
    chk("reset ctl", 32'(ctl_now()), 32'(k_fetch));
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      Op       = vecs[i].op;
      Zero     = vecs[i].zero;
      MemReady = vecs[i].mrdy;
      @(negedge clk);
      chk($sformatf("v%0d state", i), 32'(State), 32'(vecs[i].st));
      chk($sformatf("v%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("v%0d count", i), InstrCount, vecs[i].cnt);
      chk($sformatf("v%0d wrap count", i), 32'(w_cnt), 32'(vecs[i].cnt[2:0]));
      @(posedge clk);
      #1;
    end

    // Now in DECODE of LDUR; walk into MEM_RD and stall there.
    MemReady = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-reset maddr", 32'(State), 32'd4);
    @(posedge clk);
    #1;
    chk("pre-reset memrd state", 32'(State), 32'd5);
    chk("pre-reset memrd strobe", 32'(MemRead), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset state", 32'(State), 32'd0);
    chk("async reset count", InstrCount, 32'd0);
    chk("async reset wrap count", 32'(w_cnt), 32'd0);
    chk("async reset memread", 32'(MemRead), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post-reset state", 32'(State), 32'd0);
    @(negedge clk);
    chk("post-reset fetch memread", 32'(MemRead), 32'd0);
    @(posedge clk);
    #1;
    chk("post-reset decode state", 32'(State), 32'd1);
    chk("post-reset decode memread", 32'(MemRead), 32'd0);
    chk("post-reset count", InstrCount, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
